// File: rtl/osd_video_mixer.sv
// Merges C_LAYERS priority-ordered OSD layers onto background YUV video.
// Two-stage pipeline gated by the pixel enable; field-counted blink phase.
module osd_video_mixer #(
  parameter int C_DAT_W   = 8,
  parameter int C_LAYERS  = 2,
  parameter int C_BLINK_W = 6
) (
  input  logic                          CK_i,
  input  logic                          AR_i,
  input  logic                          CK_EE_i,
  input  logic                          XVD_i,
  input  logic                          OSD_ON_i,
  input  logic [C_LAYERS-1:0]           LAYER_HITs_i,
  input  logic [2*C_LAYERS-1:0]         LAYER_MODEs_i,
  input  logic [C_LAYERS*C_DAT_W-1:0]   LAYER_YYs_i,
  input  logic [C_LAYERS*C_DAT_W-1:0]   LAYER_UUs_i,
  input  logic [C_LAYERS*C_DAT_W-1:0]   LAYER_VVs_i,
  input  logic [C_BLINK_W-1:0]          BLINK_PERIODs_i,
  input  logic [C_DAT_W-1:0]            YYs_i,
  input  logic [C_DAT_W-1:0]            UUs_i,
  input  logic [C_DAT_W-1:0]            VVs_i,
  output logic [C_DAT_W-1:0]            YYs_o,
  output logic [C_DAT_W-1:0]            UUs_o,
  output logic [C_DAT_W-1:0]            VVs_o,
  output logic                          OSD_HIT_o,
  output logic                          BLINK_PHASE_o
);

  localparam logic [C_BLINK_W-1:0] BLINK_ONE = C_BLINK_W'(1);

  logic                 xvd_d;
  logic                 tick;
  logic [C_BLINK_W-1:0] blink_cnt;
  logic                 blink_phase;

  assign tick = xvd_d & ~XVD_i;

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      xvd_d       <= 1'b1;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (CK_EE_i) begin
      xvd_d <= XVD_i;
      if (BLINK_PERIODs_i == '0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (tick) begin
        // >= so a period shrunk below the running count wraps on the next tick
        if (blink_cnt >= BLINK_PERIODs_i - BLINK_ONE) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLINK_ONE;
        end
      end
    end
  end

  function automatic logic eligible(input logic [1:0] mode, input logic hit, input logic phase);
    return hit && ((mode == 2'b01) || (mode == 2'b10) || ((mode == 2'b11) && phase));
  endfunction

  logic               sel_hit;
  logic               sel_blend;
  logic [C_DAT_W-1:0] sel_y, sel_u, sel_v;

  // Walk from lowest to highest priority so the lowest eligible index overwrites.
  always_comb begin
    sel_hit   = 1'b0;
    sel_blend = 1'b0;
    sel_y     = '0;
    sel_u     = '0;
    sel_v     = '0;
    for (int k = C_LAYERS - 1; k >= 0; k--) begin
      if (OSD_ON_i && eligible(LAYER_MODEs_i[2*k +: 2], LAYER_HITs_i[k], blink_phase)) begin
        sel_hit   = 1'b1;
        sel_blend = (LAYER_MODEs_i[2*k +: 2] == 2'b10);
        sel_y     = LAYER_YYs_i[k*C_DAT_W +: C_DAT_W];
        sel_u     = LAYER_UUs_i[k*C_DAT_W +: C_DAT_W];
        sel_v     = LAYER_VVs_i[k*C_DAT_W +: C_DAT_W];
      end
    end
  end

  logic               s1_hit, s1_blend;
  logic [C_DAT_W-1:0] s1_ly, s1_lu, s1_lv;
  logic [C_DAT_W-1:0] s1_by, s1_bu, s1_bv;

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      s1_hit   <= 1'b0;
      s1_blend <= 1'b0;
      s1_ly    <= '0;
      s1_lu    <= '0;
      s1_lv    <= '0;
      s1_by    <= '0;
      s1_bu    <= '0;
      s1_bv    <= '0;
    end else if (CK_EE_i) begin
      s1_hit   <= sel_hit;
      s1_blend <= sel_blend;
      s1_ly    <= sel_y;
      s1_lu    <= sel_u;
      s1_lv    <= sel_v;
      s1_by    <= YYs_i;
      s1_bu    <= UUs_i;
      s1_bv    <= VVs_i;
    end
  end

  function automatic logic [C_DAT_W-1:0] mix(input logic [C_DAT_W-1:0] bg, input logic [C_DAT_W-1:0] ly,
                                             input logic hit, input logic blend);
    logic [C_DAT_W:0] sum;
    sum = {1'b0, bg} + {1'b0, ly} + (C_DAT_W + 1)'(1);
    if (!hit)      return bg;
    else if (blend) return sum[C_DAT_W:1];
    else           return ly;
  endfunction

  always_ff @(posedge CK_i or posedge AR_i) begin
    if (AR_i) begin
      YYs_o     <= '0;
      UUs_o     <= '0;
      VVs_o     <= '0;
      OSD_HIT_o <= 1'b0;
    end else if (CK_EE_i) begin
      YYs_o     <= mix(s1_by, s1_ly, s1_hit, s1_blend);
      UUs_o     <= mix(s1_bu, s1_lu, s1_hit, s1_blend);
      VVs_o     <= mix(s1_bv, s1_lv, s1_hit, s1_blend);
      OSD_HIT_o <= s1_hit;
    end
  end

  assign BLINK_PHASE_o = blink_phase;

endmodule

// File: tb/tb_osd_video_mixer.sv
// Bench for osd_video_mixer: vector table, blink/stall/reset sequences and
// randomized traffic checked against a pixel-level reference model.
module tb_osd_video_mixer;
  logic       CK_i = 1'b0;
  logic       AR_i = 1'b1;
  logic       CK_EE_i = 1'b0;
  logic       XVD_i = 1'b1;
  logic       OSD_ON_i = 1'b1;
  logic [1:0] hits = 2'b00;
  logic [3:0] modes = 4'b0000;
  logic [7:0] ly_y[2], ly_u[2], ly_v[2];
  logic [5:0] period = 6'd0;
  logic [7:0] bg_y = 8'h40, bg_u = 8'h80, bg_v = 8'h80;
  logic [7:0] YYs_o, UUs_o, VVs_o;
  logic       OSD_HIT_o, BLINK_PHASE_o;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [7:0] y, u, v; logic hit;} pix_t;
  pix_t m_s1, m_out;
  logic m_phase, m_xvd_d;
  int   m_cnt;

  osd_video_mixer #(.C_DAT_W(8), .C_LAYERS(2), .C_BLINK_W(6)) dut (
    .CK_i(CK_i), .AR_i(AR_i), .CK_EE_i(CK_EE_i), .XVD_i(XVD_i), .OSD_ON_i(OSD_ON_i),
    .LAYER_HITs_i(hits), .LAYER_MODEs_i(modes),
    .LAYER_YYs_i({ly_y[1], ly_y[0]}), .LAYER_UUs_i({ly_u[1], ly_u[0]}),
    .LAYER_VVs_i({ly_v[1], ly_v[0]}), .BLINK_PERIODs_i(period),
    .YYs_i(bg_y), .UUs_i(bg_u), .VVs_i(bg_v),
    .YYs_o(YYs_o), .UUs_o(UUs_o), .VVs_o(VVs_o),
    .OSD_HIT_o(OSD_HIT_o), .BLINK_PHASE_o(BLINK_PHASE_o));

  always #5 CK_i = ~CK_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '{8'h00, 8'h00, 8'h00, 1'b0};
    m_out = '{8'h00, 8'h00, 8'h00, 1'b0};
    m_phase = 1'b1;
    m_xvd_d = 1'b1;
    m_cnt = 0;
  endtask

  // One enabled pixel: what the spec says the mixer should make of the current inputs.
  task automatic model_edge();
    int win;
    pix_t np;
    logic [1:0] md;
    win = -1;
    if (OSD_ON_i)
      for (int k = 0; k < 2; k++) begin
        md = modes[2*k +: 2];
        if (win < 0 && hits[k] && (md == 2'd1 || md == 2'd2 || (md == 2'd3 && m_phase))) win = k;
      end
    if (win < 0) np = '{bg_y, bg_u, bg_v, 1'b0};
    else if (modes[2*win +: 2] == 2'd2)
      np = '{8'((int'(bg_y) + int'(ly_y[win]) + 1) / 2), 8'((int'(bg_u) + int'(ly_u[win]) + 1) / 2),
             8'((int'(bg_v) + int'(ly_v[win]) + 1) / 2), 1'b1};
    else np = '{ly_y[win], ly_u[win], ly_v[win], 1'b1};
    m_out = m_s1;
    m_s1 = np;
    if (period == 0) begin
      m_cnt = 0;
      m_phase = 1'b1;
    end else if (m_xvd_d && !XVD_i) begin
      if (m_cnt + 1 >= int'(period)) begin
        m_cnt = 0;
        m_phase = ~m_phase;
      end else m_cnt = m_cnt + 1;
    end
    m_xvd_d = XVD_i;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".y"}, YYs_o, m_out.y);
    chk({tag, ".u"}, UUs_o, m_out.u);
    chk({tag, ".v"}, VVs_o, m_out.v);
    chk({tag, ".hit"}, OSD_HIT_o, m_out.hit);
    chk({tag, ".phase"}, BLINK_PHASE_o, m_phase);
  endtask

  // Three idle clocks then one enabled clock (enable every 4th clock).
  task automatic en_step();
    CK_EE_i = 1'b0;
    repeat (3) begin @(posedge CK_i); #1; end
    CK_EE_i = 1'b1;
    @(posedge CK_i);
    model_edge();
    #1;
    CK_EE_i = 1'b0;
    check_model("step");
  endtask

  task automatic pulse(input int width);
    XVD_i = 1'b0;
    repeat (width) en_step();
    XVD_i = 1'b1;
    repeat (2) en_step();
  endtask

  typedef struct {logic on; logic [1:0] h; logic [3:0] m; logic [7:0] l0, l1, bg, ey; logic eh;} vec_t;
  vec_t vecs[11];

  initial begin
    ly_y[0] = 8'hFF; ly_y[1] = 8'h00;
    ly_u[0] = 8'h80; ly_u[1] = 8'h80;
    ly_v[0] = 8'h80; ly_v[1] = 8'h80;
    model_reset();

    vecs[0]  = '{1'b1, 2'b00, 4'b0101, 8'hFF, 8'h00, 8'h40, 8'h40, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 4'b0101, 8'hFF, 8'h00, 8'h40, 8'hFF, 1'b1};
    vecs[2]  = '{1'b1, 2'b11, 4'b0100, 8'hFF, 8'h00, 8'h40, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 2'b01, 4'b0010, 8'hFF, 8'h00, 8'h00, 8'h80, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 4'b0010, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
    vecs[5]  = '{1'b1, 2'b01, 4'b0010, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
    vecs[6]  = '{1'b1, 2'b10, 4'b0101, 8'hFF, 8'h33, 8'h40, 8'h33, 1'b1};
    vecs[7]  = '{1'b1, 2'b11, 4'b1011, 8'hFF, 8'h20, 8'h40, 8'hFF, 1'b1};
    vecs[8]  = '{1'b1, 2'b01, 4'b0000, 8'hFF, 8'h00, 8'h40, 8'h40, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 4'b1000, 8'hFF, 8'h20, 8'h41, 8'h31, 1'b1};
    vecs[10] = '{1'b0, 2'b11, 4'b0101, 8'hFF, 8'h00, 8'h40, 8'h40, 1'b0};

    // Reset and passthrough
    repeat (3) begin @(posedge CK_i); #1; CK_EE_i = ~CK_EE_i; end
    chk("rst.y", YYs_o, 8'h00);
    chk("rst.u", UUs_o, 8'h00);
    chk("rst.hit", OSD_HIT_o, 1'b0);
    chk("rst.phase", BLINK_PHASE_o, 1'b1);
    CK_EE_i = 1'b0;
    AR_i = 1'b0;
    repeat (2) en_step();
    chk("pass.y", YYs_o, 8'h40);
    chk("pass.u", UUs_o, 8'h80);
    chk("pass.v", VVs_o, 8'h80);

    // Vector table (blink disabled, phase fixed at 1)
    foreach (vecs[i]) begin
      OSD_ON_i = vecs[i].on; hits = vecs[i].h; modes = vecs[i].m;
      ly_y[0] = vecs[i].l0; ly_y[1] = vecs[i].l1; bg_y = vecs[i].bg;
      repeat (2) en_step();
      chk($sformatf("vec%0d.y", i), YYs_o, vecs[i].ey);
      chk($sformatf("vec%0d.hit", i), OSD_HIT_o, vecs[i].eh);
    end

    // Blink: layer0 blinking over opaque layer1
    OSD_ON_i = 1'b1; period = 6'd3; hits = 2'b11; modes = 4'b0111;
    ly_y[0] = 8'hFF; ly_y[1] = 8'h10; bg_y = 8'h40;
    repeat (2) en_step();
    chk("blink.vis", YYs_o, 8'hFF);
    pulse(1); pulse(1);
    chk("blink.pre", BLINK_PHASE_o, 1'b1);
    pulse(1);
    chk("blink.off", BLINK_PHASE_o, 1'b0);
    chk("blink.l1", YYs_o, 8'h10);
    pulse(5);
    pulse(1);
    chk("blink.wide_once", BLINK_PHASE_o, 1'b0);
    pulse(1);
    chk("blink.on", BLINK_PHASE_o, 1'b1);
    chk("blink.l0", YYs_o, 8'hFF);

    // Period edge cases
    period = 6'd0; en_step();
    period = 6'd6;
    repeat (4) pulse(1);
    chk("edge.cnt4", BLINK_PHASE_o, 1'b1);
    period = 6'd2;
    pulse(1);
    chk("edge.shrink", BLINK_PHASE_o, 1'b0);
    period = 6'd0; en_step();
    chk("edge.zero", BLINK_PHASE_o, 1'b1);

    // Stall: no enabled edges, inputs and XVD wiggle
    period = 6'd1;
    repeat (3) en_step();
    CK_EE_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bg_y = 8'($urandom); hits = 2'($urandom); modes = 4'($urandom);
      XVD_i = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
      @(posedge CK_i); #1;
    end
    check_model("stall");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) period = 6'($urandom_range(0, 3));
      OSD_ON_i = ($urandom_range(0, 7) != 0);
      hits = 2'($urandom); modes = 4'($urandom);
      for (int k = 0; k < 2; k++) begin
        ly_y[k] = 8'($urandom); ly_u[k] = 8'($urandom); ly_v[k] = 8'($urandom);
      end
      bg_y = 8'($urandom); bg_u = 8'($urandom); bg_v = 8'($urandom);
      XVD_i = ($urandom_range(0, 3) != 0);
      en_step();
    end

    // Async reset between clock edges
    #2 AR_i = 1'b1;
    #1;
    chk("arst.y", YYs_o, 8'h00);
    chk("arst.u", UUs_o, 8'h00);
    chk("arst.v", VVs_o, 8'h00);
    chk("arst.hit", OSD_HIT_o, 1'b0);
    chk("arst.phase", BLINK_PHASE_o, 1'b1);
    model_reset();
    @(negedge CK_i);
    AR_i = 1'b0;
    XVD_i = 1'b0; period = 6'd1;
    repeat (3) en_step();
    XVD_i = 1'b1;
    repeat (2) en_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
